// File: rtl/spi_peripheral_word.sv
// SPI mode-0 peripheral exchanging 16-bit full-duplex words, oversampled by clk.
// Define SPI_PERIPHERAL_WIRQ_EN to add the wirq (write-request) output.
module spi_peripheral_word #(
  parameter logic [15:0] IDLE_PATTERN = 16'h0F0F,
  parameter int          SYNC_STAGES  = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sclk,
  input  logic        csn,
  input  logic        copi,
  output logic        cipo,
  output logic [15:0] rx_data,
  output logic        rx_valid,
  output logic        rx_abort,
  input  logic [15:0] tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic        tx_underrun
`ifdef SPI_PERIPHERAL_WIRQ_EN
  ,
  output logic        wirq
`endif
);

  typedef enum logic [1:0] {WAIT_IDLE, IDLE, SHIFT} state_t;

  logic [SYNC_STAGES-1:0] sclk_sync, csn_sync, copi_sync;
  logic                   sclk_s, csn_s, copi_s;
  logic                   sclk_p1, csn_p1;
  logic                   sclk_rise, sclk_fall, csn_fall, csn_rise;

  state_t      state;
  logic [3:0]  bit_cnt;
  logic        wrap_pend;
  logic [15:0] rx_shift, tx_shift, hold;
  logic        rx_pend;
  logic        accept, word_start;

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign csn_s     = csn_sync[SYNC_STAGES-1];
  assign copi_s    = copi_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_p1;
  assign sclk_fall = ~sclk_s & sclk_p1;
  assign csn_fall  = ~csn_s & csn_p1;
  assign csn_rise  = csn_s & ~csn_p1;

  // A word starts on chip-select fall, or on the fall that follows the 16th rise.
  always_comb begin
    accept     = tx_valid & tx_ready;
    word_start = 1'b0;
    case (state)
      IDLE:    word_start = csn_fall;
      SHIFT:   word_start = ~csn_rise & sclk_fall & wrap_pend;
      default: word_start = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_sync   <= '0;
      csn_sync    <= '0;
      copi_sync   <= '0;
      sclk_p1     <= 1'b0;
      csn_p1      <= 1'b0;
      state       <= WAIT_IDLE;
      bit_cnt     <= 4'd0;
      wrap_pend   <= 1'b0;
      rx_shift    <= '0;
      tx_shift    <= '0;
      hold        <= '0;
      rx_pend     <= 1'b0;
      rx_data     <= '0;
      rx_valid    <= 1'b0;
      rx_abort    <= 1'b0;
      tx_ready    <= 1'b1;
      tx_underrun <= 1'b0;
      cipo        <= 1'b0;
    end else begin
      // sync stages, then edge-detect register
      sclk_sync   <= {sclk_sync[SYNC_STAGES-2:0], sclk};
      csn_sync    <= {csn_sync[SYNC_STAGES-2:0], csn};
      copi_sync   <= {copi_sync[SYNC_STAGES-2:0], copi};
      sclk_p1     <= sclk_s;
      csn_p1      <= csn_s;

      rx_valid    <= rx_pend;
      rx_pend     <= 1'b0;
      rx_abort    <= 1'b0;
      tx_underrun <= 1'b0;
      cipo        <= tx_shift[15];

      if (accept) begin
        hold     <= tx_data;
        tx_ready <= 1'b0;
      end

      // A same-cycle write cannot be full here, so it survives an underrun start.
      if (word_start) begin
        if (!tx_ready) begin
          tx_shift <= hold;
          tx_ready <= 1'b1;
        end else begin
          tx_shift    <= IDLE_PATTERN;
          tx_underrun <= 1'b1;
        end
      end

      case (state)
        WAIT_IDLE: if (csn_s) state <= IDLE;
        IDLE: begin
          if (csn_fall) begin
            bit_cnt   <= 4'd0;
            wrap_pend <= 1'b0;
            rx_shift  <= '0;
            state     <= SHIFT;
          end
        end
        SHIFT: begin
          if (csn_rise) begin
            rx_abort  <= (bit_cnt != 4'd0);
            bit_cnt   <= 4'd0;
            wrap_pend <= 1'b0;
            rx_shift  <= '0;
            tx_shift  <= '0;
            state     <= IDLE;
          end else if (sclk_rise) begin
            rx_shift  <= {rx_shift[14:0], copi_s};
            bit_cnt   <= bit_cnt + 4'd1;
            wrap_pend <= (bit_cnt == 4'd15);
            if (bit_cnt == 4'd15) begin
              rx_data <= {rx_shift[14:0], copi_s};
              rx_pend <= 1'b1;
            end
          end else if (sclk_fall) begin
            wrap_pend <= 1'b0;
            if (!wrap_pend) tx_shift <= {tx_shift[14:0], 1'b0};
          end
        end
        default: state <= WAIT_IDLE;
      endcase
    end
  end

`ifdef SPI_PERIPHERAL_WIRQ_EN
  logic idle_nxt, hold_full_nxt;

  always_comb begin
    idle_nxt = 1'b0;
    case (state)
      WAIT_IDLE: idle_nxt = csn_s;
      IDLE:      idle_nxt = ~csn_fall;
      SHIFT:     idle_nxt = csn_rise;
      default:   idle_nxt = 1'b0;
    endcase
    hold_full_nxt = accept | (~tx_ready & ~word_start);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) wirq <= 1'b0;
    else        wirq <= idle_nxt & hold_full_nxt;
  end
`endif

endmodule

// File: tb/tb_spi_peripheral_word.sv
// Directed + randomized bench for spi_peripheral_word, checked against a word-level
// model of the holding register and word-start rule.
module tb_spi_peripheral_word;

  localparam int          HALF     = 8;
  localparam logic [15:0] IDLE_PAT = 16'h0F0F;
  localparam logic [15:0] T2_RX [3] = '{16'h0001, 16'h8000, 16'hFFFF};
  localparam logic [15:0] T2_TX [4] = '{16'hBEEF, 16'h7E57, 16'h0FF0, 16'h9009};

  logic        clk = 1'b0;
  logic        rst_n, sclk, csn, copi, cipo;
  logic [15:0] rx_data, tx_data;
  logic        rx_valid, rx_abort, tx_valid, tx_ready, tx_underrun;
`ifdef SPI_PERIPHERAL_WIRQ_EN
  logic        wirq;
`endif

  int checks = 0, errors = 0;
  int n_valid = 0, n_abort = 0, n_under = 0;
  int exp_valid = 0, exp_abort = 0, exp_under = 0;
  logic [15:0] mq[$];

  spi_peripheral_word dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .csn(csn), .copi(copi), .cipo(cipo),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_abort(rx_abort),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .tx_underrun(tx_underrun)
`ifdef SPI_PERIPHERAL_WIRQ_EN
    , .wirq(wirq)
`endif
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_valid)    n_valid++;
    if (rx_abort)    n_abort++;
    if (tx_underrun) n_under++;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Word start: the held word if one is waiting, otherwise the idle pattern plus an underrun.
  function automatic logic [15:0] model_start();
    if (mq.size() != 0) return mq.pop_front();
    exp_under++;
    return IDLE_PAT;
  endfunction

  task automatic write_tx(input logic [15:0] w);
    int n = 0;
    while (tx_ready !== 1'b1 && n < 200) begin
      tick(1);
      n++;
    end
    check("tx_ready_wait", 32'(tx_ready), 32'd1);
    tx_data  = w;
    tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
    mq.push_back(w);
    check("tx_ready_fall", 32'(tx_ready), 32'd0);
  endtask

  task automatic spi_bits(input logic [15:0] w, input int nbits, output logic [15:0] got);
    got = '0;
    for (int i = 0; i < nbits; i++) begin
      copi = w[15-i];
      tick(HALF);
      got[15-i] = cipo;
      sclk = 1'b1;
      tick(HALF);
      sclk = 1'b0;
    end
    tick(5);
  endtask

  task automatic cs_low();
    csn = 1'b0;
    tick(HALF);
  endtask

  task automatic cs_high();
    tick(HALF - 5);
    csn = 1'b1;
    tick(2 * HALF);
  endtask

  task automatic do_word(input string tag, input logic [15:0] mosi, input logic [15:0] exp_cipo);
    logic [15:0] got;
    spi_bits(mosi, 16, got);
    exp_valid++;
    check({tag, "_cipo"}, 32'(got), 32'(exp_cipo));
    check({tag, "_rx_data"}, 32'(rx_data), 32'(mosi));
    check({tag, "_rx_valid_cnt"}, 32'(n_valid), 32'(exp_valid));
  endtask

  task automatic check_counts(input string tag);
    check({tag, "_valid_cnt"}, 32'(n_valid), 32'(exp_valid));
    check({tag, "_abort_cnt"}, 32'(n_abort), 32'(exp_abort));
    check({tag, "_underrun_cnt"}, 32'(n_under), 32'(exp_under));
  endtask

  initial begin
    logic [15:0] e, got, m;
    int u0, v0, nw;

    rst_n = 1'b0; sclk = 1'b0; csn = 1'b1; copi = 1'b0;
    tx_valid = 1'b0; tx_data = '0;
    tick(4);
    check("rst_cipo", 32'(cipo), 32'd0);
    check("rst_rx_data", 32'(rx_data), 32'd0);
    check("rst_rx_valid", 32'(rx_valid), 32'd0);
    check("rst_rx_abort", 32'(rx_abort), 32'd0);
    check("rst_tx_ready", 32'(tx_ready), 32'd1);
    check("rst_tx_underrun", 32'(tx_underrun), 32'd0);
`ifdef SPI_PERIPHERAL_WIRQ_EN
    check("rst_wirq", 32'(wirq), 32'd0);
`endif
    rst_n = 1'b1;
    tick(10);

    // single word with a queued tx word
    write_tx(16'hA503);
`ifdef SPI_PERIPHERAL_WIRQ_EN
    check("t1_wirq_set", 32'(wirq), 32'd1);
`endif
    u0 = n_under;
    cs_low();
    e = model_start();
    check("t1_tx_ready_back", 32'(tx_ready), 32'd1);
    check("t1_start_underrun", 32'(n_under - u0), 32'd0);
`ifdef SPI_PERIPHERAL_WIRQ_EN
    check("t1_wirq_clear", 32'(wirq), 32'd0);
`endif
    do_word("t1", 16'h1234, e);
    e = model_start();
    cs_high();
    check_counts("t1");

    // three back-to-back words, refilled every word
    write_tx(T2_TX[0]);
    u0 = n_under;
    cs_low();
    e = model_start();
    for (int j = 0; j < 3; j++) begin
      write_tx(T2_TX[j+1]);
      do_word("t2", T2_RX[j], e);
      e = model_start();
    end
    cs_high();
    check("t2_no_underrun", 32'(n_under - u0), 32'd0);
    check_counts("t2");

    // no tx word available
    u0 = n_under;
    cs_low();
    e = model_start();
    check("t3_start_underrun", 32'(n_under - u0), 32'd1);
    do_word("t3", 16'h5555, e);
    e = model_start();
    cs_high();
    check_counts("t3");

    // chip select raised after seven bits
    cs_low();
    e = model_start();
    spi_bits(16'hA5A5, 7, got);
    check("t4_partial_cipo", 32'(got[15:9]), 32'(e[15:9]));
    cs_high();
    exp_abort++;
    check_counts("t4_abort");
    cs_low();
    e = model_start();
    do_word("t4", 16'hC3C3, e);
    e = model_start();
    cs_high();
    check_counts("t4");

    // chip select held low across reset release
    rst_n = 1'b0;
    csn = 1'b0;
    tick(4);
    mq.delete();
    rst_n = 1'b1;
    tick(5);
    u0 = n_under;
    v0 = n_valid;
    for (int i = 0; i < 20; i++) begin
      copi = 1'($urandom_range(0, 1));
      tick(HALF);
      sclk = 1'b1;
      tick(HALF);
      sclk = 1'b0;
    end
    tick(5);
    check("t5_no_valid", 32'(n_valid - v0), 32'd0);
    check("t5_no_underrun", 32'(n_under - u0), 32'd0);
    check("t5_rx_data_clear", 32'(rx_data), 32'd0);
    csn = 1'b1;
    tick(2 * HALF);
    cs_low();
    e = model_start();
    do_word("t5", 16'h2468, e);
    e = model_start();
    cs_high();
    check_counts("t5");

    // randomized frames of one or two words, tx offered at random
    for (int k = 0; k < 6; k++) begin
      nw = $urandom_range(1, 2);
      if ($urandom_range(0, 1) == 1) write_tx(16'($urandom));
      cs_low();
      e = model_start();
      for (int j = 0; j < nw; j++) begin
        if ($urandom_range(0, 1) == 1) write_tx(16'($urandom));
        m = 16'($urandom);
        do_word("rnd", m, e);
        e = model_start();
      end
      cs_high();
      check("rnd_tx_ready", 32'(tx_ready), 32'd1);
    end
    check_counts("final");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
